mux4_sel_sequencer: RTL and testbench

// Upstream feeder for the 4:1 mux. Accepts a 4-bit word over a valid/ready

---
 rtl/mux4_sel_sequencer.sv | 129 ++++++++++++
 tb/tb_mux4_sel_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mux4_sel_sequencer.sv
// -----------------------------------------------------------------------------
// mux4_sel_sequencer
//
// Upstream feeder for a 4:1 mux. A 4-bit word is taken over a valid/ready
// handshake, driven on d_o, and sel_o is stepped through all four channels
// (ascending 0->3 or descending 3->0), each select held for HOLD_CYCLES
// clocks. The downstream mux output therefore carries the word one bit per
// step. A new word can be accepted during the last clock of the final step,
// so back-to-back words stream with no bubble in bit_valid_o.
//
// Parameters
//   HOLD_CYCLES : clocks each select value is held (1..255)
//   CNT_W       : hold counter width, 2**CNT_W > HOLD_CYCLES
//
// Ports
//   clk_i        : clock, all state on rising edge
//   rst_ni       : asynchronous active-low reset
//   in_valid_i   : upstream word valid
//   in_data_i    : word to serialise
//   in_dir_i     : 0 = ascending select, 1 = descending; sampled on accept
//   flush_i      : synchronous abort of the current word (beats accept)
//   in_ready_o   : a word can be accepted this cycle
//   d_o          : registered word to the mux data inputs
//   sel_o        : registered mux select
//   bit_valid_o  : d_o/sel_o form a live step
//   last_o       : current step is the final channel of the word
// -----------------------------------------------------------------------------
module mux4_sel_sequencer #(
    parameter int HOLD_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       in_valid_i,
    input  logic [3:0] in_data_i,
    input  logic       in_dir_i,
    input  logic       flush_i,
    output logic       in_ready_o,
    output logic [3:0] d_o,
    output logic [1:0] sel_o,
    output logic       bit_valid_o,
    output logic       last_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       d_q, d_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             dir_q, dir_d;
    logic             bit_valid_q, bit_valid_d;

    logic step_done;
    logic accept;

    // Final channel depends on the direction captured when the word was taken.
    assign step_done   = (hold_cnt_q == HOLD_LAST);
    assign last_o      = bit_valid_q & (dir_q ? (sel_q == 2'd0) : (sel_q == 2'd3));
    assign in_ready_o  = (state_q == IDLE) | (last_o & step_done);
    assign accept      = in_valid_i & in_ready_o & ~flush_i;

    assign d_o         = d_q;
    assign sel_o       = sel_q;
    assign bit_valid_o = bit_valid_q;

    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        sel_d       = sel_q;
        hold_cnt_d  = hold_cnt_q;
        dir_d       = dir_q;
        bit_valid_d = bit_valid_q;

        if (flush_i) begin
            // Abort: drop the word but keep d so the mux inputs stay stable.
            state_d     = IDLE;
            bit_valid_d = 1'b0;
            sel_d       = 2'd0;
            hold_cnt_d  = '0;
        end else if (accept) begin
            // Covers both a fresh start from IDLE and a gapless reload at the
            // end of the final step.
            state_d     = SHIFT;
            d_d         = in_data_i;
            dir_d       = in_dir_i;
            sel_d       = in_dir_i ? 2'd3 : 2'd0;
            hold_cnt_d  = '0;
            bit_valid_d = 1'b1;
        end else if (state_q == SHIFT) begin
            if (step_done) begin
                hold_cnt_d = '0;
                if (last_o) begin
                    state_d     = IDLE;
                    bit_valid_d = 1'b0;
                    sel_d       = 2'd0;
                end else begin
                    sel_d = dir_q ? (sel_q - 2'd1) : (sel_q + 2'd1);
                end
            end else begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            d_q         <= 4'd0;
            sel_q       <= 2'd0;
            hold_cnt_q  <= '0;
            dir_q       <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            sel_q       <= sel_d;
            hold_cnt_q  <= hold_cnt_d;
            dir_q       <= dir_d;
            bit_valid_q <= bit_valid_d;
        end
    end

endmodule

// File: tb/tb_mux4_sel_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mux4_sel_sequencer
//
// Two instances: HOLD_CYCLES=1 driven from a vector table, HOLD_CYCLES=3
// driven by a hand-written sequence. Each table row gives the inputs driven
// in a cycle and the outputs expected in that same cycle (sampled on the
// falling edge, before the inputs take effect at the next rising edge).
// -----------------------------------------------------------------------------
module tb_mux4_sel_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // HOLD_CYCLES = 1 instance
    logic       v1 = 1'b0, dir1 = 1'b0, fl1 = 1'b0;
    logic [3:0] dat1 = 4'd0;
    logic       rdy1, bv1, last1;
    logic [3:0] d1;
    logic [1:0] sel1;

    // HOLD_CYCLES = 3 instance
    logic       v3 = 1'b0, dir3 = 1'b0, fl3 = 1'b0;
    logic [3:0] dat3 = 4'd0;
    logic       rdy3, bv3, last3;
    logic [3:0] d3;
    logic [1:0] sel3;

    mux4_sel_sequencer #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(v1), .in_data_i(dat1), .in_dir_i(dir1), .flush_i(fl1),
        .in_ready_o(rdy1), .d_o(d1), .sel_o(sel1),
        .bit_valid_o(bv1), .last_o(last1)
    );

    mux4_sel_sequencer #(.HOLD_CYCLES(3), .CNT_W(8)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(v3), .in_data_i(dat3), .in_dir_i(dir3), .flush_i(fl3),
        .in_ready_o(rdy3), .d_o(d3), .sel_o(sel3),
        .bit_valid_o(bv3), .last_o(last3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic       v;
        logic [3:0] data;
        logic       dir;
        logic       fl;
        logic       rdy;
        logic       bv;
        logic [1:0] sel;
        logic       last;
        logic [3:0] d;
        logic       y;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic v, input logic [3:0] data, input logic dir,
                                input logic fl, input logic rdy, input logic bv,
                                input logic [1:0] sel, input logic last,
                                input logic [3:0] d, input logic y);
        vec_t r;
        r.v = v; r.data = data; r.dir = dir; r.fl = fl;
        r.rdy = rdy; r.bv = bv; r.sel = sel; r.last = last; r.d = d; r.y = y;
        tbl.push_back(r);
    endfunction

    initial begin
        logic [3:0] w3;
        logic       y_act;

        //     v  data    dir fl | rdy bv sel last d      y
        // Reset state, then accept 5 ascending
        add(1, 4'd5,   0, 0,   1,  0, 0,  0,  4'd0,  0);
        add(0, 4'd0,   0, 0,   0,  1, 0,  0,  4'd5,  1);
        add(0, 4'd0,   0, 0,   0,  1, 1,  0,  4'd5,  0);
        add(0, 4'd0,   0, 0,   0,  1, 2,  0,  4'd5,  1);
        add(0, 4'd0,   0, 0,   1,  1, 3,  1,  4'd5,  0);
        // Back-to-back 15 then 6, in_valid held while busy (6 ignored until ready)
        add(1, 4'd15,  0, 0,   1,  0, 0,  0,  4'd5,  1);
        add(1, 4'd6,   0, 0,   0,  1, 0,  0,  4'd15, 1);
        add(1, 4'd6,   0, 0,   0,  1, 1,  0,  4'd15, 1);
        add(1, 4'd6,   0, 0,   0,  1, 2,  0,  4'd15, 1);
        add(1, 4'd6,   0, 0,   1,  1, 3,  1,  4'd15, 1);
        add(0, 4'd0,   0, 0,   0,  1, 0,  0,  4'd6,  0);
        add(0, 4'd0,   0, 0,   0,  1, 1,  0,  4'd6,  1);
        add(0, 4'd0,   0, 0,   0,  1, 2,  0,  4'd6,  1);
        add(0, 4'd0,   0, 0,   1,  1, 3,  1,  4'd6,  0);
        // Descending 6
        add(1, 4'd6,   1, 0,   1,  0, 0,  0,  4'd6,  0);
        add(0, 4'd0,   0, 0,   0,  1, 3,  0,  4'd6,  0);
        add(0, 4'd0,   0, 0,   0,  1, 2,  0,  4'd6,  1);
        add(0, 4'd0,   0, 0,   0,  1, 1,  0,  4'd6,  1);
        add(0, 4'd0,   0, 0,   1,  1, 0,  1,  4'd6,  0);
        // flush with valid in IDLE blocks the accept; then accept 10 and flush at sel=1
        add(1, 4'd10,  0, 1,   1,  0, 0,  0,  4'd6,  0);
        add(1, 4'd10,  0, 0,   1,  0, 0,  0,  4'd6,  0);
        add(0, 4'd0,   0, 0,   0,  1, 0,  0,  4'd10, 0);
        add(1, 4'd5,   0, 1,   0,  1, 1,  0,  4'd10, 1);
        add(0, 4'd0,   0, 0,   1,  0, 0,  0,  4'd10, 0);
        add(0, 4'd0,   0, 1,   1,  0, 0,  0,  4'd10, 0);
        add(0, 4'd0,   0, 0,   1,  0, 0,  0,  4'd10, 0);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            y_act = d1[sel1];
            check("in_ready",  i, 32'(rdy1), 32'(tbl[i].rdy));
            check("bit_valid", i, 32'(bv1),  32'(tbl[i].bv));
            check("sel",       i, 32'(sel1), 32'(tbl[i].sel));
            check("last",      i, 32'(last1), 32'(tbl[i].last));
            check("d",         i, 32'(d1),   32'(tbl[i].d));
            check("y",         i, 32'(y_act), 32'(tbl[i].y));
            $display("vec %0d: v=%0b data=%0d dir=%0b flush=%0b -> rdy=%0b bv=%0b sel=%0d last=%0b d=%0d y=%0b",
                     i, tbl[i].v, tbl[i].data, tbl[i].dir, tbl[i].fl,
                     rdy1, bv1, sel1, last1, d1, y_act);
            v1 = tbl[i].v; dat1 = tbl[i].data; dir1 = tbl[i].dir; fl1 = tbl[i].fl;
        end

        // Asynchronous reset in the middle of a word
        @(negedge clk);
        v1 = 1'b1; dat1 = 4'hC; dir1 = 1'b0; fl1 = 1'b0;
        @(negedge clk);
        v1 = 1'b0;
        @(negedge clk);
        check("mid_sel_before_rst", 0, 32'(sel1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_d",         0, 32'(d1),    32'd0);
        check("rst_sel",       0, 32'(sel1),  32'd0);
        check("rst_bit_valid", 0, 32'(bv1),   32'd0);
        check("rst_last",      0, 32'(last1), 32'd0);
        $display("async reset mid-word: d=%0d sel=%0d bv=%0b last=%0b", d1, sel1, bv1, last1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready",  0, 32'(rdy1), 32'd1);
        check("rel_bit_valid", 0, 32'(bv1),  32'd0);
        $display("after release: rdy=%0b bv=%0b", rdy1, bv1);
        @(negedge clk);
        check("no_resume_bv",  0, 32'(bv1),  32'd0);

        // HOLD_CYCLES = 3: accept 9, each select held 3 clocks, 12 live cycles
        w3 = 4'd9;
        @(negedge clk);
        check("h3_idle_ready", 0, 32'(rdy3), 32'd1);
        v3 = 1'b1; dat3 = w3; dir3 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            v3 = 1'b0;
            y_act = d3[sel3];
            check("h3_bit_valid", k, 32'(bv3),   32'd1);
            check("h3_sel",       k, 32'(sel3),  k / 3);
            check("h3_y",         k, 32'(y_act), 32'(w3[k / 3]));
            check("h3_last",      k, 32'(last3), (k >= 9) ? 1 : 0);
            check("h3_in_ready",  k, 32'(rdy3),  (k == 11) ? 1 : 0);
            $display("hold3 cycle %0d: bv=%0b sel=%0d y=%0b last=%0b rdy=%0b",
                     k, bv3, sel3, y_act, last3, rdy3);
        end
        @(negedge clk);
        check("h3_end_bv",  12, 32'(bv3),  32'd0);
        check("h3_end_sel", 12, 32'(sel3), 32'd0);
        check("h3_end_d",   12, 32'(d3),   32'(w3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
